// File: rtl/pe_result_collector.sv
// Accumulates adder-tree partial sums into per-group signed results and queues them in a FWFT FIFO.
// Optional feature: define PE_ACC_SAT_EN to saturate the accumulator on signed overflow (default: wrap).
module pe_result_collector #(
   parameter int DATA_WIDTH = 32,
   parameter int ACC_WIDTH  = 40,
   parameter int LEN_WIDTH  = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          in_valid,
   input  logic [DATA_WIDTH-1:0]         in_data,
   input  logic                          in_last,
   output logic                          in_ready,
   input  logic                          clear,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [ACC_WIDTH-1:0]          out_data,
   output logic [LEN_WIDTH-1:0]          out_count,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   ovf_q, ovf_d;
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;

   logic [ACC_WIDTH-1:0]   data_mem [FIFO_DEPTH];
   logic [LEN_WIDTH-1:0]   cnt_mem  [FIFO_DEPTH];

   logic                   accept, push, pop, full, empty;
   logic [ACC_WIDTH-1:0]   acc_base, beat_ext, sum, acc_new;
   logic [LEN_WIDTH-1:0]   cnt_base, cnt_new;
   logic                   add_ovf, cnt_sat;

   // FIFO status depends only on registered pointers, keeping in_ready/out_valid free of input paths
   assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty      = (wr_ptr_q == rd_ptr_q);
   assign fifo_level = wr_ptr_q - rd_ptr_q;
   assign in_ready   = !full;
   assign out_valid  = !empty;
   assign overflow   = ovf_q;

   assign out_data   = out_valid ? data_mem[rd_ptr_q[AW-1:0]] : '0;
   assign out_count  = out_valid ? cnt_mem[rd_ptr_q[AW-1:0]]  : '0;

   assign accept     = in_valid && in_ready && !clear;
   assign push       = accept && in_last;
   assign pop        = out_valid && out_ready && !clear;

   assign acc_base   = (state_q == IDLE) ? '0 : acc_q;
   assign cnt_base   = (state_q == IDLE) ? '0 : cnt_q;
   assign beat_ext   = ACC_WIDTH'($signed(in_data));
   assign sum        = acc_base + beat_ext;
   assign add_ovf    = (acc_base[ACC_WIDTH-1] == beat_ext[ACC_WIDTH-1]) &&
                       (sum[ACC_WIDTH-1] != acc_base[ACC_WIDTH-1]);
   assign cnt_sat    = &cnt_base;
   assign cnt_new    = cnt_sat ? cnt_base : cnt_base + 1'b1;

`ifdef PE_ACC_SAT_EN
   logic sat_q, sat_d;

   // Once clamped, the accumulator ignores further beats until the group closes
   always_comb begin
      acc_new = sum;
      if (sat_q)
         acc_new = acc_base;
      else if (add_ovf)
         acc_new = acc_base[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
   end

   always_comb begin
      sat_d = sat_q;
      if (clear)
         sat_d = 1'b0;
      else if (accept)
         sat_d = in_last ? 1'b0 : (sat_q || add_ovf);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) sat_q <= 1'b0;
      else       sat_q <= sat_d;
   end
`else
   assign acc_new = sum;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clear)
         state_d = IDLE;
      else if (accept)
         state_d = in_last ? IDLE : ACCUM;
   end

   always_comb begin
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clear) begin
         acc_d    = '0;
         cnt_d    = '0;
         ovf_d    = 1'b0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (accept) begin
            acc_d = in_last ? '0 : acc_new;
            cnt_d = in_last ? '0 : cnt_new;
            ovf_d = ovf_q || add_ovf || cnt_sat;
         end
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc_q    <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Result storage carries no reset; validity is tracked purely by the pointers
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr_q[AW-1:0]] <= acc_new;
         cnt_mem[wr_ptr_q[AW-1:0]]  <= cnt_new;
      end
   end

endmodule

// File: tb/tb_pe_result_collector.sv
// Scoreboard bench for pe_result_collector: default 40-bit instance plus a 32-bit instance for overflow.
module tb_pe_result_collector;
   localparam int DW  = 32;
   localparam int AW  = 40;
   localparam int LW  = 8;
   localparam int FD  = 8;
   localparam int LVW = $clog2(FD) + 1;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic           in_valid = 0, in_last = 0, clear = 0, out_ready = 0;
   logic [DW-1:0]  in_data = '0;
   logic           in_ready, out_valid, overflow;
   logic [AW-1:0]  out_data;
   logic [LW-1:0]  out_count;
   logic [LVW-1:0] fifo_level;

   logic           v32 = 0, l32 = 0, clr32 = 0, ordy32 = 0;
   logic [DW-1:0]  d32 = '0;
   logic           irdy32, ovld32, ovf32;
   logic [31:0]    odata32;
   logic [LW-1:0]  ocnt32;
   logic [LVW-1:0] lvl32;

   pe_result_collector #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(in_ready), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_count(out_count), .fifo_level(fifo_level), .overflow(overflow));

   pe_result_collector #(.DATA_WIDTH(DW), .ACC_WIDTH(32), .LEN_WIDTH(LW), .FIFO_DEPTH(FD)) dut32 (
      .clk(clk), .rstn(rstn), .in_valid(v32), .in_data(d32), .in_last(l32),
      .in_ready(irdy32), .clear(clr32), .out_valid(ovld32), .out_ready(ordy32),
      .out_data(odata32), .out_count(ocnt32), .fifo_level(lvl32), .overflow(ovf32));

   int n_checks = 0;
   int n_errors = 0;
   logic [AW-1:0] exp_data [$];
   logic [LW-1:0] exp_cnt  [$];
   logic [AW-1:0] mdl_acc = '0;
   int            mdl_cnt = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every pop the DUT performs is compared against the oldest expected result
   always @(negedge clk) begin
      if (rstn && out_valid && out_ready && !clear) begin
         if (exp_data.size() == 0) begin
            check_eq("sb_underflow", 64'(exp_data.size()), 64'd1);
         end else begin
            logic [AW-1:0] ed;
            logic [LW-1:0] ec;
            ed = exp_data.pop_front();
            ec = exp_cnt.pop_front();
            $display("result data=0x%0h count=%0d (expected 0x%0h / %0d)", out_data, out_count, ed, ec);
            check_eq("sb_data", 64'(out_data), 64'(ed));
            check_eq("sb_count", 64'(out_count), 64'(ec));
         end
      end
   end

   task automatic model_beat(input logic [DW-1:0] d, input logic l);
      mdl_acc = mdl_acc + AW'($signed(d));
      mdl_cnt++;
      if (l) begin
         exp_data.push_back(mdl_acc);
         exp_cnt.push_back(LW'(mdl_cnt));
         mdl_acc = '0;
         mdl_cnt = 0;
      end
   endtask

   // Presents one beat and holds it until in_ready allows acceptance (bounded)
   task automatic send_beat(input logic [DW-1:0] d, input logic l);
      int waited;
      waited   = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(negedge clk);
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         check_eq("accept_timeout", 64'(in_ready), 64'd1);
         in_valid = 1'b0;
         return;
      end
      model_beat(d, l);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      int waited;
      repeat (12) @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_fifo_level", 64'(fifo_level), 64'd0);
      check_eq("rst_overflow", 64'(overflow), 64'd0);
      check_eq("rst_in_ready", 64'(in_ready), 64'd1);
      check_eq("rst_out_data", 64'(out_data), 64'd0);
      check_eq("rst_out_count", 64'(out_count), 64'd0);

      // Multi-beat group with one-cycle result latency
      @(posedge clk); #1;
      out_ready = 1'b1;
      send_beat(32'h284, 1'b0);
      send_beat(32'h2C4, 1'b0);
      in_valid = 1'b1; in_data = 32'h10; in_last = 1'b1;
      model_beat(32'h10, 1'b1);
      @(negedge clk);
      check_eq("lat_pre_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      @(negedge clk);
      check_eq("lat_post_valid", 64'(out_valid), 64'd1);
      check_eq("lat_data", 64'(out_data), 64'h558);
      repeat (3) @(posedge clk);
      #1;

      // Sign extension of a single-beat group
      send_beat(32'hFFFF_FFFF, 1'b1);
      @(negedge clk);
      check_eq("sext_data", 64'(out_data), 64'hFF_FFFF_FFFF);
      check_eq("sext_count", 64'(out_count), 64'd1);
      repeat (3) @(posedge clk);
      #1;

      // Backpressure: fill to full, hold a ninth beat, then drain
      out_ready = 1'b0;
      for (int i = 1; i <= 8; i++) send_beat(DW'(i), 1'b1);
      @(negedge clk);
      check_eq("full_level", 64'(fifo_level), 64'd8);
      check_eq("full_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 32'd9; in_last = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("held9_level", 64'(fifo_level), 64'd8);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check_eq("rdy_same_cycle", 64'(in_ready), 64'd0);
      @(negedge clk);
      check_eq("rdy_next_cycle", 64'(in_ready), 64'd1);
      check_eq("level_after_pop", 64'(fifo_level), 64'd7);
      repeat (10) @(posedge clk);
      #1;

      // Simultaneous push and pop at level 3
      out_ready = 1'b0;
      send_beat(32'd10, 1'b1);
      send_beat(32'd11, 1'b1);
      send_beat(32'd12, 1'b1);
      @(negedge clk);
      check_eq("level3", 64'(fifo_level), 64'd3);
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 32'd13; in_last = 1'b1; out_ready = 1'b1;
      model_beat(32'd13, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      check_eq("pushpop_level", 64'(fifo_level), 64'd3);
      @(posedge clk); #1;
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;

      // Clear concurrent with a beat and a pop: everything flushed, beat lost
      out_ready = 1'b0;
      send_beat(32'h20, 1'b1);
      send_beat(32'h55, 1'b0);
      in_valid = 1'b1; in_data = 32'h77; in_last = 1'b1; clear = 1'b1; out_ready = 1'b1;
      exp_data.delete();
      exp_cnt.delete();
      mdl_acc = '0;
      mdl_cnt = 0;
      @(posedge clk); #1;
      clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      @(negedge clk);
      check_eq("clear_level", 64'(fifo_level), 64'd0);
      check_eq("clear_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      send_beat(32'd5, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("ovf_default", 64'(overflow), 64'd0);

      // Signed overflow on the 32-bit accumulator instance
      @(posedge clk); #1;
      v32 = 1'b1; d32 = 32'h7FFF_FFFF; l32 = 1'b0;
      @(posedge clk); #1;
      l32 = 1'b1;
      @(posedge clk); #1;
      v32 = 1'b0; l32 = 1'b0;
      @(negedge clk);
      check_eq("ovf32_valid", 64'(ovld32), 64'd1);
`ifdef PE_ACC_SAT_EN
      check_eq("ovf32_data", 64'(odata32), 64'h7FFF_FFFF);
`else
      check_eq("ovf32_data", 64'(odata32), 64'hFFFF_FFFE);
`endif
      check_eq("ovf32_count", 64'(ocnt32), 64'd2);
      check_eq("ovf32_flag", 64'(ovf32), 64'd1);
      $display("overflow group data=0x%0h count=%0d flag=%0d", odata32, ocnt32, ovf32);
      @(posedge clk); #1;
      clr32 = 1'b1;
      @(posedge clk); #1;
      clr32 = 1'b0;
      @(negedge clk);
      check_eq("ovf32_cleared", 64'(ovf32), 64'd0);
      check_eq("ovf32_flushed", 64'(ovld32), 64'd0);

      // Let any remaining expected results drain
      waited = 0;
      while (exp_data.size() != 0 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check_eq("sb_drained", 64'(exp_data.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/pe_result_collector.md
# pe_result_collector

Downstream consumer of the PE adder tree. Takes the final reduced sum of each processing cycle (the 32-bit second-stage adder output), accumulates consecutive partial sums into one wide signed result per vector group, and queues finished results in a small first-word-fall-through FIFO. A valid/ready port drains the FIFO toward writeback or the host. This extends the 4-lane PE to dot products longer than one vector.

## Interface
- DATA_WIDTH, 32: width of each incoming partial sum, signed two's complement.
- ACC_WIDTH, 40: accumulator and result width, signed. Must be ≥ DATA_WIDTH.
- LEN_WIDTH, 8: width of the per-group beat counter.
- FIFO_DEPTH, 8: number of result entries. Power of two, ≥ 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- in_valid  in  1  partial sum present on in_data.
- in_data  in  DATA_WIDTH  partial sum from the adder tree.
- in_last  in  1  marks the final beat of a group; qualified by in_valid.
- in_ready  out  1  collector can accept a beat.
- clear  in  1  synchronous flush of the accumulator, counter, FIFO and overflow flag.
- out_valid  out  1  FIFO head holds a result.
- out_ready  in  1  consumer takes the head.
- out_data  out  ACC_WIDTH  accumulated group result.
- out_count  out  LEN_WIDTH  number of beats in that group.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current number of entries.
- overflow  out  1  sticky; set on accumulator or counter overflow.

## Operation
- A beat is accepted when in_valid && in_ready. in_ready = (fifo_level != FIFO_DEPTH). It is conservative: low whenever the FIFO is full, even for non-last beats.
- The state machine has two states.
  - IDLE: acc = 0, cnt = 0.
  - ACCUM: a group is open.
- Transitions:
  - IDLE → ACCUM on an accepted beat with in_last = 0.
  - ACCUM → IDLE on an accepted beat with in_last = 1.
  - IDLE → IDLE on an accepted beat with in_last = 1. This is a single-beat group.
- On each accepted beat:
  - acc_next = acc + sign_extend(in_data) to ACC_WIDTH.
  - cnt_next = cnt + 1. At 2^LEN_WIDTH−1 the counter holds its value and sets overflow.
- On an accepted beat with in_last = 1:
  - {acc_next, cnt_next} is pushed to the FIFO.
  - acc and cnt return to 0 in the same edge.
- Signed overflow of the ACC_WIDTH add sets overflow. The result value on overflow is defined under Configuration.
- FIFO pop occurs when out_valid && out_ready. A simultaneous push and pop leaves fifo_level unchanged. No push ever occurs when full.
- clear has top priority:
  - acc, cnt, FIFO pointers and overflow go to 0, and the state goes to IDLE.
  - A beat or pop presented in the same cycle is discarded.
- overflow clears only on clear or reset.

## Timing
- Reset (asynchronous, rstn low):
  - Outputs: out_valid = 0, out_data = 0, out_count = 0, fifo_level = 0, overflow = 0, in_ready = 1.
  - Internal: state IDLE, acc = 0, cnt = 0.
- Reset asserted mid-group discards the partial accumulation and all queued results.
- Latency: a last beat accepted at edge N gives out_valid = 1 with the result from cycle N+1 (after edge N) when the FIFO was empty. There is no combinational path from in_* to out_*.
- out_data and out_count are driven from the FIFO head register and hold stable while out_valid && !out_ready.
- in_ready is a function of registered fifo_level only. A pop in the same cycle does not raise it until the next cycle.
- Pointer wrap: read and write pointers are $clog2(FIFO_DEPTH)+1 bits. full = MSBs differ and the rest are equal.
- Throughput: one beat per cycle while the FIFO is not full.

## Configuration
- PE_ACC_SAT_EN
  - Defined: on signed overflow, acc clamps to +(2^(ACC_WIDTH−1)−1) or −2^(ACC_WIDTH−1) and stays clamped for the rest of the group. overflow is set.
  - Undefined: acc wraps modulo 2^ACC_WIDTH. overflow is still set.

## Test plan
- Reset state: hold rstn low 12 cycles, then release → out_valid = 0, fifo_level = 0, overflow = 0, in_ready = 1.
- Multi-beat group: beats 0x284, 0x2C4, 0x10 (last) on consecutive cycles, out_ready = 1 → one result out_data = 0x558, out_count = 3, out_valid one cycle after the last beat.
- Sign extension: single beat in_data = 0xFFFFFFFF, in_last = 1 → out_data = 0xFF_FFFF_FFFF (−1), out_count = 1.
- Backpressure: out_ready = 0, push 8 single-beat groups with values 1..8 → fifo_level = 8 and in_ready = 0; a held 9th beat is not accepted. Then set out_ready = 1 → drains in order 1..8, and in_ready rises the cycle after the first pop.
- Simultaneous push/pop with level 3 → level stays 3. A clear in the same cycle as a beat → level 0, acc 0, and that beat is lost.
- Overflow: two beats of 0x7FFFFFFF with ACC_WIDTH = 32.
  - PE_ACC_SAT_EN defined → out_data = 0x7FFFFFFF, overflow = 1.
  - PE_ACC_SAT_EN undefined → out_data = 0xFFFFFFFE, overflow = 1.
